// File: rtl/alu_issue_stage.sv
// Operand/issue stage feeding a combinational ALU: registered opcode/a/b out, x/y captured one edge later and written back.
// Latency: accept at edge N, writeback at N+1, done high for one cycle; cmd_ready low in ISSUE/DONE (one command per 3 cycles).
module alu_issue_stage #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 4,
  parameter int AW     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_opcode,
  input  logic [AW-1:0]     cmd_rs1,
  input  logic [AW-1:0]     cmd_rs2,
  input  logic [AW-1:0]     cmd_rd,
  input  logic              cmd_wr_y,
  input  logic              ld_valid,
  input  logic [AW-1:0]     ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [3:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_x,
  input  logic [DATA_W-1:0] alu_y,
  output logic [DATA_W-1:0] res_x,
  output logic [DATA_W-1:0] res_y,
  output logic              done,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [AW-1:0]     rd_q, rd_d;
  logic              wr_y_q, wr_y_d;
  logic [3:0]        opcode_q, opcode_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] res_x_q, res_x_d;
  logic [DATA_W-1:0] res_y_q, res_y_d;
  logic [AW-1:0]     rd_y;

  // NREGS is 2**AW, so the AW-bit increment wraps NREGS-1 to 0 for free.
  assign rd_y = rd_q + AW'(1);

  always_comb begin
    state_d  = state_q;
    regs_d   = regs_q;
    rd_d     = rd_q;
    wr_y_d   = wr_y_q;
    opcode_d = opcode_q;
    a_d      = a_q;
    b_d      = b_q;
    res_x_d  = res_x_q;
    res_y_d  = res_y_q;

    if (ld_valid) begin
      regs_d[ld_addr] = ld_data;
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          // Operands come from regs_q, so a same-edge load is not visible here.
          opcode_d = cmd_opcode;
          a_d      = regs_q[cmd_rs1];
          b_d      = regs_q[cmd_rs2];
          rd_d     = cmd_rd;
          wr_y_d   = cmd_wr_y;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        res_x_d      = alu_x;
        res_y_d      = alu_y;
        regs_d[rd_q] = alu_x;
        if (wr_y_q) begin
          regs_d[rd_y] = alu_y;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      rd_q     <= '0;
      wr_y_q   <= 1'b0;
      opcode_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_x_q  <= '0;
      res_y_q  <= '0;
    end else begin
      state_q  <= state_d;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      rd_q     <= rd_d;
      wr_y_q   <= wr_y_d;
      opcode_q <= opcode_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_x_q  <= res_x_d;
      res_y_q  <= res_y_d;
    end
  end

  assign cmd_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign alu_opcode = opcode_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign res_x      = res_x_q;
  assign res_y      = res_y_q;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Operand/issue stage placed directly upstream of alu_behavioral. It owns a small 8-bit register file and accepts ALU commands over a valid/ready handshake.
- For each command it drives registered opcode/a/b into the ALU and captures the ALU's x/y outputs one cycle later. The captured results are written back to the register file and reported with a one-cycle done pulse.
- Keeps the combinational ALU off any register-to-register timing path.

Parameters:
- DATA_W, 8, operand/result width; must match ALU a/b/x/y width.
- NREGS, 4, register file depth; power of two, ≥2.
- AW, 2, register address width, equal to log2(NREGS).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous reset, active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  stage can accept a command.
- cmd_opcode  input  4  ALU opcode, passed through unmodified.
- cmd_rs1  input  AW  source register for ALU a.
- cmd_rs2  input  AW  source register for ALU b.
- cmd_rd  input  AW  destination register for ALU x.
- cmd_wr_y  input  1  also write ALU y to register (cmd_rd+1) mod NREGS.
- ld_valid  input  1  direct register load strobe.
- ld_addr  input  AW  load address.
- ld_data  input  DATA_W  load data.
- alu_opcode  output  4  to ALU opcode.
- alu_a  output  DATA_W  to ALU a.
- alu_b  output  DATA_W  to ALU b.
- alu_x  input  DATA_W  from ALU x (combinational).
- alu_y  input  DATA_W  from ALU y (combinational).
- res_x  output  DATA_W  last captured x.
- res_y  output  DATA_W  last captured y.
- done  output  1  one-cycle pulse, res_x/res_y newly valid.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset: all registers, alu_opcode/alu_a/alu_b, res_x/res_y go to 0; done=0; state=IDLE. A reset mid-command aborts it with no writeback. Reset overrides every other event.
- States:
  - IDLE: cmd_ready=1. On cmd_valid, accept the command: latch alu_opcode←cmd_opcode, alu_a←reg[cmd_rs1], alu_b←reg[cmd_rs2], and latch rd/wr_y. Go to ISSUE.
  - ISSUE: cmd_ready=0. The ALU settles during this cycle. At the closing edge: res_x←alu_x, res_y←alu_y; reg[rd]←alu_x; if wr_y, reg[(rd+1) mod NREGS]←alu_y. done←1. Go to DONE.
  - DONE: done=1 and cmd_ready=0 for this cycle only. Always return to IDLE.
- Latency and throughput: accept at edge N, writeback at edge N+1, done high in cycle N+1..N+2. Maximum throughput is one command per 3 cycles.
- cmd_ready is a function of state only; it does not depend on cmd_valid.
- Operand read ordering:
  - Operands are the register values before the accept edge.
  - An ld_valid on that same edge is not seen by the command.
  - rs1==rs2 is legal.
  - rd may equal rs1 or rs2.
- Loads: ld_valid is honoured in every state. If it targets the same register as a writeback on the same edge, the writeback wins. Loads to other registers on that edge proceed normally.
- wr_y with (rd+1) wrapping: rd=NREGS-1 writes y to reg 0.
- Between commands, alu_opcode/alu_a/alu_b and res_x/res_y hold their last values.
- No arithmetic is performed in this block. Widths pass through unchanged.

Test Plan:
- Bench ALU stub for all scenarios: x=a+b (mod 256), y=a-b.
- Reset then idle: after rst, all outputs 0, cmd_ready=1, busy=0, done=0.
- Load r0=0x0A, r1=0x05, then command rs1=0, rs2=1, rd=2, wr_y=1, opcode=0000:
  - alu_a=0x0A and alu_b=0x05 one cycle after accept.
  - done pulses one cycle later with res_x=0x0F, res_y=0x05.
  - r2=0x0F and r3=0x05, confirmed by a follow-up command reading them.
- Wrap and alias: r3=0xFF, r0=0x01, command rs1=3, rs2=0, rd=3, wr_y=1:
  - res_x=0x00, res_y=0xFE.
  - r3=0x00 and r0=0xFE (y wraps to register 0).
- Load collision: issue a command with rd=2 and assert ld_valid addr=2 data=0xAA on the writeback edge → r2 holds the ALU x value, not 0xAA.
- Backpressure: hold cmd_valid high continuously → exactly one accept every 3 cycles. cmd_ready is low in ISSUE and DONE. Opcodes 0000..1111 each reach alu_opcode in order.
- Reset mid-operation: assert rst in the ISSUE cycle → no register write, done stays 0, state IDLE next cycle, all outputs 0.
